// File: rtl/conv_datapath_sequencer.sv
// conv_datapath_sequencer: top-level control FSM of the Conv2d datapath.
// For every output kernel it loads the kernel's weights into the kernel BRAM,
// then, per input channel, latches the kernel register, streams the channel
// image row by row (first / mid / last) and lets the PE accumulate.
// Only control strobes leave this block; no data passes through it.
module conv_datapath_sequencer #(
  parameter int ROW_CNT_WIDTH = 7,
  parameter int KCNT_WIDTH    = 9
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [KCNT_WIDTH-1:0]    NUM_KERNELS,
  input  logic [7:0]               IMAGE_SIZE,
  input  logic                     reg_last_chan,
  input  logic                     last_loading_1ker,
  input  logic                     last_channel,
  input  logic                     Kernel_BRAM_IDLE,
  input  logic                     Done_1row,
  input  logic                     Input_line_buffer_IDLE,
  input  logic                     PE_ready,
  input  logic                     PE_with_buffers_IDLE,
  input  logic [ROW_CNT_WIDTH-1:0] top_row_counter_out,
  output logic                     slave_select,
  output logic                     en_reg_last_chan,
  output logic                     rst_reg_last_chan,
  output logic                     Kernel_BRAM_Reset,
  output logic                     Input_line_buffer_Reset,
  output logic                     PE_with_buffers_Reset,
  output logic                     load_BRAM_dina,
  output logic                     update_BRAM_doutb,
  output logic                     Load_kernel_reg,
  output logic                     Stream_first_row,
  output logic                     Stream_mid_row,
  output logic                     Stream_last_row,
  output logic                     en_top_row_counter,
  output logic                     rst_top_row_counter,
  output logic                     busy,
  output logic                     layer_done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_LOAD_KER  = 4'd2,
    S_KREG      = 4'd3,
    S_WAIT_PE   = 4'd4,
    S_FIRST_ROW = 4'd5,
    S_MID_ROW   = 4'd6,
    S_LAST_ROW  = 4'd7,
    S_CHAN_END  = 4'd8,
    S_KER_END   = 4'd9,
    S_INIT_K    = 4'd10,
    S_DONE      = 4'd11
  } state_t;

  state_t                   state_q, state_d;
  logic [KCNT_WIDTH-1:0]    kcnt_q, kcnt_d;
  logic [KCNT_WIDTH-1:0]    nker_q, nker_d;
  logic [7:0]               img_q, img_d;

  logic                     start_ok_s;
  logic [KCNT_WIDTH:0]      kcnt_next_s;
  logic [KCNT_WIDTH:0]      nker_eff_s;
  logic [ROW_CNT_WIDTH+7:0] row_ext_s;
  logic [ROW_CNT_WIDTH+7:0] mid_last_s;

  // A layer may only begin with an image of at least 2x2.
  assign start_ok_s  = start && (IMAGE_SIZE >= 8'd2);
  // Kernel count of zero behaves as a single kernel.
  assign nker_eff_s  = (nker_q == {KCNT_WIDTH{1'b0}}) ? {{KCNT_WIDTH{1'b0}}, 1'b1}
                                                      : {1'b0, nker_q};
  assign kcnt_next_s = {1'b0, kcnt_q} + {{KCNT_WIDTH{1'b0}}, 1'b1};
  // Last mid row is the one finishing while the counter still shows IMAGE_SIZE-3.
  assign row_ext_s   = {8'd0, top_row_counter_out};
  assign mid_last_s  = {{ROW_CNT_WIDTH{1'b0}}, img_q - 8'd3};

  // State, kernel counter and sampled layer configuration registers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      kcnt_q  <= {KCNT_WIDTH{1'b0}};
      nker_q  <= {KCNT_WIDTH{1'b0}};
      img_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      nker_q  <= nker_d;
      img_q   <= img_d;
    end
  end

  // Next-state logic: layer sequencing driven by datapath status.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    nker_d  = nker_q;
    img_d   = img_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d = S_INIT;
          nker_d  = NUM_KERNELS;
          img_d   = IMAGE_SIZE;
          kcnt_d  = {KCNT_WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT, S_INIT_K: state_d = S_LOAD_KER;
      S_LOAD_KER: begin
        if (last_loading_1ker && !Kernel_BRAM_IDLE) begin
          state_d = S_KREG;
        end else begin
          state_d = S_LOAD_KER;
        end
      end
      S_KREG: state_d = S_WAIT_PE;
      S_WAIT_PE: begin
        if (PE_ready) begin
          state_d = S_FIRST_ROW;
        end else begin
          state_d = S_WAIT_PE;
        end
      end
      S_FIRST_ROW: begin
        if (Done_1row) begin
          state_d = (img_q == 8'd2) ? S_LAST_ROW : S_MID_ROW;
        end else begin
          state_d = S_FIRST_ROW;
        end
      end
      S_MID_ROW: begin
        if (Done_1row && (row_ext_s == mid_last_s)) begin
          state_d = S_LAST_ROW;
        end else begin
          state_d = S_MID_ROW;
        end
      end
      S_LAST_ROW: begin
        if (Done_1row) begin
          state_d = S_CHAN_END;
        end else begin
          state_d = S_LAST_ROW;
        end
      end
      S_CHAN_END: begin
        if (Input_line_buffer_IDLE) begin
          state_d = reg_last_chan ? S_KER_END : S_KREG;
        end else begin
          state_d = S_CHAN_END;
        end
      end
      S_KER_END: begin
        if (!PE_with_buffers_IDLE) begin
          state_d = S_KER_END;
        end else if (kcnt_next_s >= nker_eff_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_INIT_K;
          kcnt_d  = kcnt_q + {{(KCNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        kcnt_d  = {KCNT_WIDTH{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        kcnt_d  = {KCNT_WIDTH{1'b0}};
      end
    endcase
  end

  // Output decode from the registered state; two enables are qualified by status inputs.
  always_comb begin
    slave_select            = 1'b0;
    en_reg_last_chan        = 1'b0;
    rst_reg_last_chan       = 1'b1;
    Kernel_BRAM_Reset       = 1'b0;
    Input_line_buffer_Reset = 1'b0;
    PE_with_buffers_Reset   = 1'b0;
    load_BRAM_dina          = 1'b0;
    update_BRAM_doutb       = 1'b0;
    Load_kernel_reg         = 1'b0;
    Stream_first_row        = 1'b0;
    Stream_mid_row          = 1'b0;
    Stream_last_row         = 1'b0;
    en_top_row_counter      = 1'b0;
    rst_top_row_counter     = 1'b0;
    busy                    = 1'b1;
    layer_done              = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_INIT: begin
        Kernel_BRAM_Reset       = 1'b1;
        Input_line_buffer_Reset = 1'b1;
        PE_with_buffers_Reset   = 1'b1;
        rst_top_row_counter     = 1'b1;
        rst_reg_last_chan       = 1'b0;
      end
      S_INIT_K: begin
        Kernel_BRAM_Reset       = 1'b1;
        Input_line_buffer_Reset = 1'b1;
        rst_top_row_counter     = 1'b1;
        rst_reg_last_chan       = 1'b0;
      end
      S_LOAD_KER: load_BRAM_dina = 1'b1;
      S_KREG: begin
        update_BRAM_doutb = 1'b1;
        Load_kernel_reg   = 1'b1;
        en_reg_last_chan  = last_channel;
      end
      S_FIRST_ROW: begin
        slave_select        = 1'b1;
        Stream_first_row    = 1'b1;
        rst_top_row_counter = 1'b1;
      end
      S_MID_ROW: begin
        slave_select       = 1'b1;
        Stream_mid_row     = 1'b1;
        en_top_row_counter = Done_1row;
      end
      S_LAST_ROW: begin
        slave_select    = 1'b1;
        Stream_last_row = 1'b1;
      end
      S_WAIT_PE, S_CHAN_END, S_KER_END: busy = 1'b1;
      S_DONE: layer_done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_conv_datapath_sequencer.sv
// tb_conv_datapath_sequencer: the bench emulates the datapath (kernel BRAM,
// line buffer, PE, last-channel flag and row counter) with randomized timing
// and records a per-layer trace of control events, which is compared with a
// trace built directly from the layer parameters.
module tb_conv_datapath_sequencer;

  localparam byte EV_P = 8'h50; // INIT (with PE reset)
  localparam byte EV_K = 8'h4B; // INIT_K (no PE reset)
  localparam byte EV_L = 8'h4C; // entered kernel load
  localparam byte EV_R = 8'h52; // kernel register load
  localparam byte EV_F = 8'h46; // first row finished
  localparam byte EV_M = 8'h4D; // mid row finished
  localparam byte EV_C = 8'h43; // row counter increment
  localparam byte EV_T = 8'h54; // last row finished
  localparam byte EV_D = 8'h44; // layer done

  logic       clk = 1'b0;
  logic       Reset, start;
  logic [8:0] NUM_KERNELS;
  logic [7:0] IMAGE_SIZE;
  logic       reg_last_chan, last_loading_1ker, last_channel, Kernel_BRAM_IDLE;
  logic       Done_1row, Input_line_buffer_IDLE, PE_ready, PE_with_buffers_IDLE;
  logic [6:0] top_row_counter_out;
  logic       slave_select, en_reg_last_chan, rst_reg_last_chan;
  logic       Kernel_BRAM_Reset, Input_line_buffer_Reset, PE_with_buffers_Reset;
  logic       load_BRAM_dina, update_BRAM_doutb, Load_kernel_reg;
  logic       Stream_first_row, Stream_mid_row, Stream_last_row;
  logic       en_top_row_counter, rst_top_row_counter, busy, layer_done;

  conv_datapath_sequencer #(.ROW_CNT_WIDTH(7), .KCNT_WIDTH(9)) dut (
    .clk(clk), .Reset(Reset), .start(start),
    .NUM_KERNELS(NUM_KERNELS), .IMAGE_SIZE(IMAGE_SIZE),
    .reg_last_chan(reg_last_chan), .last_loading_1ker(last_loading_1ker),
    .last_channel(last_channel), .Kernel_BRAM_IDLE(Kernel_BRAM_IDLE),
    .Done_1row(Done_1row), .Input_line_buffer_IDLE(Input_line_buffer_IDLE),
    .PE_ready(PE_ready), .PE_with_buffers_IDLE(PE_with_buffers_IDLE),
    .top_row_counter_out(top_row_counter_out),
    .slave_select(slave_select), .en_reg_last_chan(en_reg_last_chan),
    .rst_reg_last_chan(rst_reg_last_chan), .Kernel_BRAM_Reset(Kernel_BRAM_Reset),
    .Input_line_buffer_Reset(Input_line_buffer_Reset),
    .PE_with_buffers_Reset(PE_with_buffers_Reset),
    .load_BRAM_dina(load_BRAM_dina), .update_BRAM_doutb(update_BRAM_doutb),
    .Load_kernel_reg(Load_kernel_reg), .Stream_first_row(Stream_first_row),
    .Stream_mid_row(Stream_mid_row), .Stream_last_row(Stream_last_row),
    .en_top_row_counter(en_top_row_counter), .rst_top_row_counter(rst_top_row_counter),
    .busy(busy), .layer_done(layer_done)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int  n_checks = 0, n_pass = 0;
  byte trace[$];
  byte exp_q[$];
  int  cyc = 0, viol = 0, lc_clr_cnt = 0, done_seen = 0, done_cyc = 0;
  int  last_t_cyc = 0, stall_left = 0, run_id = 0;
  bit  t_seen = 1'b0, start_req = 1'b0, rnd_start = 1'b0, cfg_rnd_idle = 1'b0;
  int  cfg_nch = 1, cfg_rmin = 1, cfg_rmax = 1;
  int  load_cnt = 0, load_len = 1, row_cyc = 0, row_len = 1, chan_idx = 0;
  bit  prev_load = 1'b0;
  logic [6:0] row_ctr = 7'd0;
  logic lc_flag = 1'b0;
  logic p_rst_cnt = 1'b0, p_en_cnt = 1'b0, p_rst_lc_n = 1'b1, p_en_lc = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic logic [15:0] outs();
    return {slave_select, en_reg_last_chan, rst_reg_last_chan, Kernel_BRAM_Reset,
            Input_line_buffer_Reset, PE_with_buffers_Reset, load_BRAM_dina,
            update_BRAM_doutb, Load_kernel_reg, Stream_first_row, Stream_mid_row,
            Stream_last_row, en_top_row_counter, rst_top_row_counter, busy, layer_done};
  endfunction

  // One clock of datapath emulation: update emulated registers, drive status, record events.
  task automatic step();
    logic strobe_any;
    @(negedge clk);
    cyc++;
    if (p_rst_cnt) row_ctr = 7'd0;
    else if (p_en_cnt) row_ctr = row_ctr + 7'd1;
    if (!p_rst_lc_n) lc_flag = 1'b0;
    else if (p_en_lc) lc_flag = 1'b1;
    top_row_counter_out = row_ctr;
    reg_last_chan = lc_flag;
    start = start_req || (rnd_start && (load_BRAM_dina || ($urandom % 4 == 0)));
    start_req = 1'b0;
    if (load_BRAM_dina) begin
      load_cnt++;
      if (load_cnt >= load_len) begin
        last_loading_1ker = 1'b1; Kernel_BRAM_IDLE = 1'b0;
      end else begin
        last_loading_1ker = ($urandom % 4 == 0); Kernel_BRAM_IDLE = last_loading_1ker;
      end
    end else begin
      load_cnt = 0; load_len = $urandom_range(1, 4);
      last_loading_1ker = ($urandom % 6 == 0); Kernel_BRAM_IDLE = 1'($urandom % 2);
    end
    last_channel = Load_kernel_reg ? (chan_idx == cfg_nch - 1) : 1'($urandom % 2);
    strobe_any = Stream_first_row | Stream_mid_row | Stream_last_row;
    if (strobe_any) begin
      row_cyc++;
      if (row_cyc >= row_len) begin
        Done_1row = 1'b1; row_cyc = 0; row_len = $urandom_range(cfg_rmin, cfg_rmax);
      end else begin
        Done_1row = 1'b0;
      end
    end else begin
      row_cyc = 0; Done_1row = ($urandom % 7 == 0);
    end
    PE_ready = ($urandom % 3 == 0);
    Input_line_buffer_IDLE = cfg_rnd_idle ? ($urandom % 3 != 0) : 1'b1;
    if (stall_left > 0 && t_seen && (cyc - last_t_cyc >= 2)) begin
      PE_with_buffers_IDLE = 1'b0; stall_left--;
    end else begin
      PE_with_buffers_IDLE = cfg_rnd_idle ? ($urandom % 3 != 0) : 1'b1;
    end
    #1;
    if (Kernel_BRAM_Reset) begin
      trace.push_back(PE_with_buffers_Reset ? EV_P : EV_K); chan_idx = 0;
    end
    if (PE_with_buffers_Reset && !Kernel_BRAM_Reset) viol++;
    if (Input_line_buffer_Reset != Kernel_BRAM_Reset) viol++;
    if (!rst_reg_last_chan) lc_clr_cnt++;
    if (rst_reg_last_chan == Kernel_BRAM_Reset) viol++;
    if (load_BRAM_dina && !prev_load) trace.push_back(EV_L);
    prev_load = load_BRAM_dina;
    if (load_BRAM_dina && slave_select) viol++;
    if (strobe_any != slave_select) viol++;
    if (Load_kernel_reg) begin
      trace.push_back(EV_R);
      if (en_reg_last_chan != last_channel || !update_BRAM_doutb) viol++;
      chan_idx++;
    end else if (en_reg_last_chan || update_BRAM_doutb) viol++;
    if (int'(Stream_first_row) + int'(Stream_mid_row) + int'(Stream_last_row) > 1) viol++;
    if (Stream_first_row && !rst_top_row_counter) viol++;
    if (Done_1row && Stream_first_row) trace.push_back(EV_F);
    if (Done_1row && Stream_mid_row) trace.push_back(EV_M);
    if (Done_1row && Stream_last_row) begin
      trace.push_back(EV_T); last_t_cyc = cyc; t_seen = 1'b1;
    end
    if (en_top_row_counter) begin
      trace.push_back(EV_C);
      if (!(Stream_mid_row && Done_1row)) viol++;
    end
    if (layer_done) begin
      trace.push_back(EV_D); done_cyc = cyc; done_seen++;
    end
    p_rst_cnt = rst_top_row_counter; p_en_cnt = en_top_row_counter;
    p_rst_lc_n = rst_reg_last_chan; p_en_lc = en_reg_last_chan;
  endtask

  task automatic set_cfg(input int nch, input bit rnd);
    cfg_nch = nch; cfg_rnd_idle = rnd;
    cfg_rmin = rnd ? 1 : 10; cfg_rmax = rnd ? 5 : 10;
    row_len = cfg_rmin; row_cyc = 0;
  endtask

  // Runs one layer and compares it against the event trace implied by its parameters.
  task automatic run_layer(input int img, input int nk, input int nch, input int stall, input bit rnd);
    int nk_eff, budget;
    run_id++;
    nk_eff = (nk == 0) ? 1 : nk;
    exp_q.delete();
    for (int k = 0; k < nk_eff; k++) begin
      exp_q.push_back(k == 0 ? EV_P : EV_K);
      exp_q.push_back(EV_L);
      for (int c = 0; c < nch; c++) begin
        exp_q.push_back(EV_R);
        exp_q.push_back(EV_F);
        for (int m = 0; m < img - 2; m++) begin
          exp_q.push_back(EV_M); exp_q.push_back(EV_C);
        end
        exp_q.push_back(EV_T);
      end
    end
    exp_q.push_back(EV_D);
    trace.delete(); viol = 0; lc_clr_cnt = 0; done_seen = 0; t_seen = 1'b0;
    stall_left = stall;
    set_cfg(nch, rnd);
    IMAGE_SIZE = 8'(img); NUM_KERNELS = 9'(nk); start_req = 1'b1;
    step();
    rnd_start = rnd;
    step();
    IMAGE_SIZE = 8'($urandom); NUM_KERNELS = 9'($urandom);
    budget = 20000;
    while (done_seen == 0 && budget > 0) begin
      step(); budget--;
    end
    rnd_start = 1'b0;
    step();
    check_val($sformatf("r%0d_done_once", run_id), done_seen, 1);
    check_val($sformatf("r%0d_busy_after_done", run_id), busy, 0);
    check_val($sformatf("r%0d_protocol_viol", run_id), viol, 0);
    check_val($sformatf("r%0d_lastchan_clears", run_id), lc_clr_cnt, nk_eff);
    check_val($sformatf("r%0d_trace_len", run_id), trace.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
      check_val($sformatf("r%0d_trace_ev%0d", run_id, i), trace[i], exp_q[i]);
    if (!rnd) check_val($sformatf("r%0d_done_latency", run_id), done_cyc - last_t_cyc, 3 + stall);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; NUM_KERNELS = 9'd1; IMAGE_SIZE = 8'd4;
    reg_last_chan = 1'b0; last_loading_1ker = 1'b0; last_channel = 1'b0;
    Kernel_BRAM_IDLE = 1'b1; Done_1row = 1'b0; Input_line_buffer_IDLE = 1'b1;
    PE_ready = 1'b0; PE_with_buffers_IDLE = 1'b1; top_row_counter_out = 7'd0;
    #1;
    check_val("reset_outputs", outs(), 16'h2000);
    step(); step();
    Reset = 1'b0;
    check_val("idle_busy_after_reset", busy, 0);

    run_layer(4, 1, 1, 0, 1'b0);   // basic single kernel / channel
    run_layer(2, 1, 2, 0, 1'b0);   // 2x2 image: no mid rows
    run_layer(5, 2, 3, 0, 1'b0);   // multi kernel, multi channel

    // Asynchronous reset in the middle of a mid row.
    set_cfg(1, 1'b0);
    IMAGE_SIZE = 8'd6; NUM_KERNELS = 9'd1; start_req = 1'b1;
    for (int i = 0; i < 2000 && !Stream_mid_row; i++) step();
    check_val("reached_mid_row", Stream_mid_row, 1);
    Reset = 1'b1;
    #1;
    check_val("reset_mid_row_outputs", outs(), 16'h2000);
    step(); step();
    Reset = 1'b0;
    run_layer(4, 1, 1, 0, 1'b0);   // restart replays INIT

    // Start with an illegal image size is ignored.
    trace.delete();
    IMAGE_SIZE = 8'd1; start_req = 1'b1;
    step(); step(); step();
    check_val("ignore_size1_busy", busy, 0);
    check_val("ignore_size1_events", trace.size(), 0);
    IMAGE_SIZE = 8'd0; start_req = 1'b1;
    step(); step(); step();
    check_val("ignore_size0_busy", busy, 0);
    check_val("ignore_size0_events", trace.size(), 0);

    run_layer(3, 1, 1, 20, 1'b0);  // PE drain stall of 20 cycles
    run_layer(3, 0, 2, 0, 1'b0);   // zero kernels behaves as one

    for (int r = 0; r < 6; r++)
      run_layer($urandom_range(2, 7), $urandom_range(0, 3), $urandom_range(1, 3), 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
